// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the direct-mapped instruction cache.
package icache_pkg;

    localparam int unsigned DEF_LINE_WORDS = 4;
    localparam int unsigned DEF_NUM_LINES  = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_UPDATE = 2'd2
    } icache_state_e;

    function automatic int unsigned off_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned idx_width(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    function automatic int unsigned tag_width(input int unsigned line_words,
                                              input int unsigned num_lines);
        return 30 - off_width(line_words) - idx_width(num_lines);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data arrays for the instruction cache: combinational read port,
// per-word data write, tag+valid write and a whole-cache invalidate.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
    localparam int unsigned OFF = off_width(LINE_WORDS),
    localparam int unsigned IDX = idx_width(NUM_LINES),
    localparam int unsigned TAG = tag_width(LINE_WORDS, NUM_LINES)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [IDX-1:0]  rd_index_i,
    input  logic [OFF-1:0]  rd_offset_i,
    output logic            rd_valid_o,
    output logic [TAG-1:0]  rd_tag_o,
    output logic [31:0]     rd_data_o,
    input  logic [IDX-1:0]  wr_index_i,
    input  logic            data_we_i,
    input  logic [OFF-1:0]  wr_offset_i,
    input  logic [31:0]     wr_data_i,
    input  logic            tag_we_i,
    input  logic [TAG-1:0]  wr_tag_i,
    input  logic            inv_all_i
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG-1:0]       tag_q  [NUM_LINES];
    logic [31:0]          data_q [NUM_LINES][LINE_WORDS];

    assign rd_valid_o = valid_q[rd_index_i];
    assign rd_tag_o   = tag_q[rd_index_i];
    assign rd_data_o  = data_q[rd_index_i][rd_offset_i];

    // Invalidate-all outranks the install so a flushed refill never becomes valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
        end else if (inv_all_i) begin
            valid_q <= '0;
        end else if (tag_we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (tag_we_i) begin
            tag_q[wr_index_i] <= wr_tag_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (data_we_i) begin
            data_q[wr_index_i][wr_offset_i] <= wr_data_i;
        end
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with single-outstanding line refill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module instruction_cache
    import icache_pkg::*;
#(
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned NUM_LINES  = DEF_NUM_LINES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] PC,
    input  logic        flush,
    output logic [31:0] instruction,
    output logic        hit,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned OFF    = off_width(LINE_WORDS);
    localparam int unsigned IDX    = idx_width(NUM_LINES);
    localparam int unsigned TAG    = tag_width(LINE_WORDS, NUM_LINES);
    localparam int unsigned LINE_W = TAG + IDX;
    localparam logic [OFF-1:0] BEAT_LAST = OFF'(LINE_WORDS - 1);

    icache_state_e     state_q;
    logic [OFF-1:0]    beat_q;
    logic [OFF-1:0]    beat_d;
    logic [LINE_W-1:0] miss_line_q;
    logic              flush_pending_q;
    logic              mem_req_q;
    logic [31:0]       mem_addr_q;

    logic [OFF-1:0]    pc_off;
    logic [IDX-1:0]    pc_idx;
    logic [TAG-1:0]    pc_tag;
    logic [1:0]        unused_pc_bits;
    logic              rd_valid;
    logic [TAG-1:0]    rd_tag;
    logic [31:0]       rd_data;
    logic              kill_fill;
    logic              inv_all;
    logic              data_we;
    logic              tag_we;

    assign pc_off         = PC[2 +: OFF];
    assign pc_idx         = PC[2+OFF +: IDX];
    assign pc_tag         = PC[31 -: TAG];
    assign unused_pc_bits = PC[1:0];

    assign hit         = (state_q == ST_IDLE) && rd_valid && (rd_tag == pc_tag);
    assign instruction = rd_data;
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign beat_d      = beat_q + OFF'(1);

    // A flush seen in the install cycle itself also suppresses the install.
    assign kill_fill = flush_pending_q || flush;
    assign inv_all   = ((state_q == ST_IDLE) && flush) ||
                       ((state_q == ST_UPDATE) && kill_fill);
    assign data_we   = (state_q == ST_REFILL) && mem_ready;
    assign tag_we    = (state_q == ST_UPDATE) && !kill_fill;

    icache_line_store #(
        .LINE_WORDS (LINE_WORDS),
        .NUM_LINES  (NUM_LINES)
    ) u_store (
        .clk_i       (clock),
        .rst_i       (reset),
        .rd_index_i  (pc_idx),
        .rd_offset_i (pc_off),
        .rd_valid_o  (rd_valid),
        .rd_tag_o    (rd_tag),
        .rd_data_o   (rd_data),
        .wr_index_i  (miss_line_q[IDX-1:0]),
        .data_we_i   (data_we),
        .wr_offset_i (beat_q),
        .wr_data_i   (mem_rdata),
        .tag_we_i    (tag_we),
        .wr_tag_i    (miss_line_q[LINE_W-1 -: TAG]),
        .inv_all_i   (inv_all)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            beat_q          <= '0;
            miss_line_q     <= '0;
            flush_pending_q <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_addr_q      <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!flush && !hit) begin
                        state_q     <= ST_REFILL;
                        miss_line_q <= PC[31:2+OFF];
                        beat_q      <= '0;
                        mem_req_q   <= 1'b1;
                        mem_addr_q  <= {PC[31:2+OFF], {OFF{1'b0}}, 2'b00};
                    end
                end
                ST_REFILL: begin
                    if (flush) begin
                        flush_pending_q <= 1'b1;
                    end
                    if (mem_ready) begin
                        beat_q <= beat_d;
                        if (beat_q == BEAT_LAST) begin
                            state_q   <= ST_UPDATE;
                            mem_req_q <= 1'b0;
                        end else begin
                            mem_addr_q <= {miss_line_q, beat_d, 2'b00};
                        end
                    end
                end
                ST_UPDATE: begin
                    flush_pending_q <= 1'b0;
                    state_q         <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_q;
    logic [31:0] miss_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if ((state_q == ST_IDLE) && !hit && !flush) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Scoreboard bench for instruction_cache: a line-level cache model predicts each
// cycle's outputs, a negedge monitor compares them against the DUT.
module tb_instruction_cache;

    logic        clock;
    logic        reset;
    logic [31:0] PC;
    logic        flush;
    logic [31:0] instruction;
    logic        hit;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_rdata;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count;
    logic [31:0] miss_count;
`endif

    instruction_cache #(
        .LINE_WORDS (4),
        .NUM_LINES  (16)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .PC          (PC),
        .flush       (flush),
        .instruction (instruction),
        .hit         (hit),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count   (hit_count),
        .miss_count  (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        bit          chk;
        bit          hit;
        logic [31:0] instr;
        bit          req;
        bit          chk_addr;
        logic [31:0] addr;
        int unsigned hc;
        int unsigned mc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: which memory line (byte address >> 4) each index holds, -1 if none.
    int          m_line [16];
    bit          m_known = 0;
    int          m_phase = 0;      // 0 looking up, 1 fetching words, 2 installing
    int unsigned m_refill_line = 0;
    int unsigned m_beats = 0;
    int unsigned m_wait = 0;
    int unsigned m_lat = 0;
    bit          m_pend = 0;
    bit          m_addr_zero = 0;
    int unsigned m_hits = 0;
    int unsigned m_misses = 0;
    int          lat_mode = 2;     // fixed ready latency, or -1 for random per beat

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a;
    endfunction

    function automatic void clear_lines();
        foreach (m_line[i]) m_line[i] = -1;
    endfunction

    function automatic void pick_lat();
        m_lat = (lat_mode < 0) ? $urandom_range(0, 3) : lat_mode;
    endfunction

    task automatic step(input logic [31:0] pc, input bit fl, input bit rs);
        exp_t        e;
        bit          rdy;
        int unsigned line;
        int unsigned idx;
        @(posedge clock);
        #1;
        line       = pc >> 4;
        idx        = line % 16;
        e.chk      = m_known;
        e.hit      = m_known && (m_phase == 0) && (m_line[idx] == int'(line));
        e.instr    = memfn({pc[31:2], 2'b00});
        e.req      = (m_phase == 1);
        e.chk_addr = (m_phase == 1) || m_addr_zero;
        e.addr     = (m_phase == 1) ? (m_refill_line * 16 + m_beats * 4) : 32'd0;
        e.hc       = m_hits;
        e.mc       = m_misses;
        rdy        = (m_phase == 1) && (m_wait >= m_lat);
        PC         = pc;
        flush      = fl;
        reset      = rs;
        mem_ready  = rdy;
        mem_rdata  = rdy ? memfn(e.addr) : 32'hDEAD_BEEF;
        exp_q.push_back(e);
        if (rs) begin
            clear_lines();
            m_known     = 1;
            m_phase     = 0;
            m_pend      = 0;
            m_beats     = 0;
            m_addr_zero = 1;
            m_hits      = 0;
            m_misses    = 0;
        end else if (m_known) begin
            if (e.hit) m_hits++;
            case (m_phase)
                0: begin
                    if (fl) begin
                        clear_lines();
                    end else if (!e.hit) begin
                        m_phase       = 1;
                        m_refill_line = line;
                        m_beats       = 0;
                        m_wait        = 0;
                        m_addr_zero   = 0;
                        m_misses++;
                        pick_lat();
                    end
                end
                1: begin
                    if (fl) m_pend = 1;
                    if (rdy) begin
                        m_beats++;
                        m_wait = 0;
                        pick_lat();
                        if (m_beats == 4) m_phase = 2;
                    end else begin
                        m_wait++;
                    end
                end
                default: begin
                    if (m_pend || fl) clear_lines();
                    else m_line[m_refill_line % 16] = int'(m_refill_line);
                    m_pend  = 0;
                    m_phase = 0;
                end
            endcase
        end
    endtask

    task automatic fill(input logic [31:0] pc);
        step(pc, 0, 0);
        for (int i = 0; i < 60 && m_phase != 0; i++) step(pc, 0, 0);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
                check("hit", 32'(hit), 32'(e.hit));
                if (e.hit) check("instruction", instruction, e.instr);
                check("mem_req", 32'(mem_req), 32'(e.req));
                if (e.chk_addr) check("mem_addr", mem_addr, e.addr);
`ifdef ICACHE_STATS_EN
                check("hit_count", hit_count, e.hc);
                check("miss_count", miss_count, e.mc);
`endif
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        logic [31:0] cur_pc;
        int unsigned ln;
        PC        = '0;
        flush     = 1'b0;
        reset     = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        clear_lines();

        // Cold miss, then hit on another word of the same line.
        step(32'h0, 0, 1);
        step(32'h0, 0, 1);
        fill(32'h0);
        step(32'h0, 0, 0);
        step(32'h8, 0, 0);

        // Conflict on index 0.
        fill(32'h100);
        step(32'h10C, 0, 0);
        fill(32'h0);
        step(32'h4, 0, 0);

        // Redirect during refill.
        step(32'h0, 0, 1);
        step(32'h0, 0, 0);
        for (int i = 0; i < 60 && m_phase != 0; i++) step(32'h40, 0, 0);
        fill(32'h40);
        step(32'h0, 0, 0);
        step(32'h4C, 0, 0);

        // Flush during beat 2.
        step(32'h0, 0, 1);
        step(32'h0, 0, 0);
        for (int i = 0; i < 60 && !(m_phase == 1 && m_beats == 2); i++) step(32'h0, 0, 0);
        step(32'h0, 1, 0);
        for (int i = 0; i < 60 && m_phase != 0; i++) step(32'h0, 0, 0);
        fill(32'h0);
        step(32'h0, 0, 0);

        // Reset at beat 1.
        step(32'h80, 0, 0);
        for (int i = 0; i < 60 && !(m_phase == 1 && m_beats == 1); i++) step(32'h80, 0, 0);
        step(32'h80, 0, 1);
        fill(32'h0);
        step(32'h0, 0, 0);

        // Flush in idle: this cycle still hits, next lookup misses.
        step(32'h0, 1, 0);
        fill(32'h0);

        // Counters: one miss then three hit cycles.
        step(32'h0, 0, 1);
        fill(32'h0);
        step(32'h0, 0, 0);
        step(32'h4, 0, 0);
        step(32'h8, 0, 0);
        step(32'h40, 0, 0);
`ifdef ICACHE_STATS_EN
        @(negedge clock);
        check("stats_hit_count", hit_count, 32'd3);
        check("stats_miss_count", miss_count, 32'd1);
`endif
        for (int i = 0; i < 60 && m_phase != 0; i++) step(32'h40, 0, 0);

        // Miss penalty with ready always high.
        lat_mode = 0;
        step(32'h300, 0, 1);
        step(32'h300, 0, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(32'h300, 0, 0);
            n++;
            @(negedge clock);
            if (hit === 1'b1) break;
        end
        check("miss_penalty", 32'(n), 32'd6);

        // Randomized traffic.
        lat_mode = -1;
        cur_pc   = 32'h0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                ln     = $urandom_range(0, 3) * 1024 + $urandom_range(0, 39);
                cur_pc = ln * 16 + $urandom_range(0, 3) * 4 + $urandom_range(0, 3);
            end
            step(cur_pc, $urandom_range(0, 49) == 0, $urandom_range(0, 199) == 0);
        end

        step(32'h0, 0, 0);
        @(negedge clock);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
